upzero_mc: RTL and testbench
============================

// Module: upzero_mc
// PURPOSE
//  Multi-channel, parametrised ADPCM zero-predictor coefficient update (G.722 UPZERO), the successor to the single-channel 6-tap unit.
//  Holds per-channel coefficient (bli) and delay-line (dlti) state internally and updates it one tap per cycle.
//  Sits in the encoder/decoder band path after quantisation, before the zero-section filter (filtez).
// PARAMETERS
//  NCH      1    number of independent channels; per-channel bli/dlti state
//  NTAPS    6    zero-predictor taps per channel
//  DW       32   coefficient width, signed
//  DLT_W    17   dlt sample width, signed; dlti entries stored at this width
//  LEAK_SH  8    leak shift: bli*(2^LEAK_SH-1)/2^LEAK_SH
//  STEP     128  sign-sign adaptation step magnitude
//  COEF_MAX 32767  saturation bound, used only with UPZERO_SAT_EN
// PORTS
//  ap_clk   in   1      clock
//  ap_rst   in   1      synchronous reset, active-high
//  ap_start in   1      start request; sampled only in IDLE
//  ap_done  out  1      one-cycle pulse on completion
//  ap_idle  out  1      1 while in IDLE
//  ap_ready out  1      one-cycle pulse, coincident with ap_done
//  ch       in   CW     channel to update, CW=max(1,$clog2(NCH)); captured with ap_start
//  dlt      in   DLT_W  new quantised difference sample; captured with ap_start
//  rd_ch    in   CW     readback channel
//  rd_idx   in   TW     readback tap, TW=max(1,$clog2(NTAPS))
//  bli_rd   out  DW     registered bli[rd_ch][rd_idx]; 1-cycle latency
//  dlti_rd  out  DLT_W  registered dlti[rd_ch][rd_idx]; 1-cycle latency
// BEHAVIOUR
//  Reset: FSM -> IDLE; all bli and dlti = 0; ap_done = ap_ready = 0; ap_idle = 1; bli_rd = dlti_rd = 0.
//  FSM: IDLE -(ap_start)-> UPD -(tap==NTAPS-1)-> SHIFT -> DONE -> IDLE. ap_start outside IDLE is ignored.
//  Latency: start accepted at edge T; ap_done high during cycle T+NTAPS+2; ap_idle high again from T+NTAPS+3.
//  UPD, tap i (one per cycle, i=0..NTAPS-1): leak = ((bli<<<LEAK_SH) - bli) >>> LEAK_SH.
//   Computed at DW+LEAK_SH bits; arithmetic shift; floors toward -inf.
//   dlt_cap==0: bli[i] <= leak.
//   dlt_cap!=0: bli[i] <= leak + (sgn(dlt_cap*dlti[i]) >= 0 ? +STEP : -STEP).
//    Sign is taken from the full-precision product; a zero product counts as non-negative.
//  SHIFT: dlti[k] <= dlti[k-1] for k=NTAPS-1..1; dlti[0] <= dlt_cap. Uses the pre-shift dlti values read during UPD.
//  Without UPZERO_SAT_EN the result wraps modulo 2^DW.
//  Only channel ch_cap is touched; other channels are bit-exact unchanged.
//  Readback is always live. During a busy update it returns the currently stored value; coherent only while ap_idle.
//  ap_rst mid-update aborts the update and clears all state; no ap_done pulse.
//  ch >= NCH: update is discarded (no state change), but handshake timing is unchanged.
// CONFIGURATION
//  UPZERO_SAT_EN defined: each updated bli is clamped to [-COEF_MAX, +COEF_MAX] after the step is added.
//  UPZERO_SAT_EN undefined: no clamp, two's-complement wrap at DW; COEF_MAX is unused.
// STRUCTURE
//  Package upzero_pkg: FSM state enum (IDLE, UPD, SHIFT, DONE); default constants LEAK_SH, STEP, DLT_W.
//  Package also holds a function sat_dw() used by the saturation option.
//  One sub-module, upzero_tap_alu: combinational leak + sign-sign step (+ optional clamp) for a single tap.
//  Top level holds FSM, tap counter, captured ch/dlt, state arrays and readback registers.
// TESTING (NCH=2, NTAPS=6, defaults unless noted)
//  Reset, then start ch0 dlt=5 (all state 0) -> done at T+8.
//   ch0 bli[0..5]=128 (zero product counts non-negative); dlti[0]=5, others 0; ch1 all 0.
//  Then start ch0 dlt=0 -> bli[0..5]=127; dlti[0]=0, dlti[1]=5.
//  Preload ch0 bli[0]=127, dlti[0]=5; start dlt=-3 -> bli[0]=126-128=-2; dlti[0]=-3, dlti[1]=5.
//  Start dlt=0 with bli[0]=-2 -> bli[0]=-2 (floor of -510/256); ap_start pulsed while busy is ignored (single ap_done).
//  UPZERO_SAT_EN, COEF_MAX=200: bli=128, dlti>0, dlt>0 -> bli=200.
//   Same stimulus without the macro -> bli=255.
//  Assert ap_rst at UPD tap 3 -> all state 0, ap_idle=1 next cycle, no ap_done.
//   Start ch=1 afterwards updates only ch1.

Source files
------------

// File: rtl/upzero_pkg.sv
// Shared definitions for the multi-channel G.722 zero-predictor update (upzero_mc).
// Holds the FSM state type, the default arithmetic constants and the clamp helper
// used when the design is built with UPZERO_SAT_EN defined.
package upzero_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UPD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } upz_state_t;

  localparam int LEAK_SH = 8;
  localparam int STEP    = 128;
  localparam int DLT_W   = 17;

  // Clamp a wide signed value to [-lim, +lim]; the caller truncates to DW afterwards
  function automatic logic signed [63:0] sat_dw(input logic signed [63:0] val,
                                                input logic signed [63:0] lim);
    if (val > lim) begin
      return lim;
    end else if (val < -lim) begin
      return -lim;
    end else begin
      return val;
    end
  endfunction

endpackage

// File: rtl/upzero_tap_alu.sv
// Single-tap coefficient update: leak the old coefficient by (2^LEAK_SH-1)/2^LEAK_SH,
// then add a sign-sign step whose direction comes from sgn(dlt*dlti).
// Build option UPZERO_SAT_EN: clamp the result to [-COEF_MAX, +COEF_MAX]; otherwise
// the result wraps modulo 2^DW.
module upzero_tap_alu
  import upzero_pkg::*;
#(
  parameter int DW       = 32,
  parameter int DLT_W    = 17,
  parameter int LEAK_SH  = 8,
  parameter int STEP     = 128,
  parameter int COEF_MAX = 32767
) (
  input  logic signed [DW-1:0]    bli,
  input  logic signed [DLT_W-1:0] dlti,
  input  logic signed [DLT_W-1:0] dlt,
  output logic signed [DW-1:0]    bli_new
);

  localparam int XW = DW + LEAK_SH;

  logic signed [XW-1:0] bli_x;
  logic signed [DW-1:0] leak;
  logic                 step_neg;

  // Leak at widened precision so the floor-shift cannot overflow; a zero product
  // (either operand zero) counts as non-negative, so only opposite nonzero signs step down
  always_comb begin
    bli_x    = {{LEAK_SH{bli[DW-1]}}, bli};
    leak     = DW'(((bli_x <<< LEAK_SH) - bli_x) >>> LEAK_SH);
    step_neg = (dlt != '0) && (dlti != '0) && (dlt[DLT_W-1] ^ dlti[DLT_W-1]);
  end

`ifdef UPZERO_SAT_EN
  logic signed [63:0] sum_w;

  // Add the step at 64 bits and clamp before narrowing back to DW
  always_comb begin
    sum_w = 64'(leak);
    if (dlt != '0) begin
      sum_w = step_neg ? (sum_w - 64'(STEP)) : (sum_w + 64'(STEP));
    end
    bli_new = DW'(sat_dw(sum_w, 64'(COEF_MAX)));
  end
`else
  // Add the step at DW bits and let it wrap
  always_comb begin
    bli_new = leak;
    if (dlt != '0) begin
      bli_new = step_neg ? (leak - DW'(STEP)) : (leak + DW'(STEP));
    end
  end
`endif

endmodule

// File: rtl/upzero_mc.sv
// Multi-channel G.722 UPZERO: per-channel bli/dlti state, one tap updated per cycle,
// then the delay line is shifted with the captured dlt. ap_* handshake, registered readback.
// Build option UPZERO_SAT_EN (see upzero_tap_alu) selects coefficient clamping.
module upzero_mc
  import upzero_pkg::*;
#(
  parameter int NCH      = 1,
  parameter int NTAPS    = 6,
  parameter int DW       = 32,
  parameter int DLT_W    = upzero_pkg::DLT_W,
  parameter int LEAK_SH  = upzero_pkg::LEAK_SH,
  parameter int STEP     = upzero_pkg::STEP,
  parameter int COEF_MAX = 32767,
  localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int TW      = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             ap_start,
  output logic             ap_done,
  output logic             ap_idle,
  output logic             ap_ready,
  input  logic [CW-1:0]    ch,
  input  logic [DLT_W-1:0] dlt,
  input  logic [CW-1:0]    rd_ch,
  input  logic [TW-1:0]    rd_idx,
  output logic [DW-1:0]    bli_rd,
  output logic [DLT_W-1:0] dlti_rd
);

  localparam logic [TW-1:0] TAP_LAST = TW'(NTAPS - 1);

  upz_state_t              state;
  upz_state_t              state_nxt;
  logic [TW-1:0]           tap;
  logic [CW-1:0]           ch_cap;
  logic signed [DLT_W-1:0] dlt_cap;
  logic                    ch_ok;
  logic [CW-1:0]           ch_sel;
  logic signed [DW-1:0]    alu_bli;
  logic signed [DLT_W-1:0] alu_dlti;
  logic signed [DW-1:0]    alu_out;

  logic signed [DW-1:0]    bli_mem  [NCH][NTAPS];
  logic signed [DLT_W-1:0] dlti_mem [NCH][NTAPS];

  // Out-of-range channels still run the handshake but never write; index 0 keeps reads legal
  always_comb begin
    ch_ok    = int'(ch_cap) < NCH;
    ch_sel   = ch_ok ? ch_cap : '0;
    alu_bli  = bli_mem[ch_sel][tap];
    alu_dlti = dlti_mem[ch_sel][tap];
  end

  upzero_tap_alu #(
    .DW       (DW),
    .DLT_W    (DLT_W),
    .LEAK_SH  (LEAK_SH),
    .STEP     (STEP),
    .COEF_MAX (COEF_MAX)
  ) u_alu (
    .bli     (alu_bli),
    .dlti    (alu_dlti),
    .dlt     (dlt_cap),
    .bli_new (alu_out)
  );

  // Next-state and handshake outputs; ap_ready mirrors ap_done
  always_comb begin
    state_nxt = state;
    ap_done   = 1'b0;
    ap_ready  = 1'b0;
    ap_idle   = 1'b0;
    case (state)
      IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) state_nxt = UPD;
      end
      UPD: begin
        if (tap == TAP_LAST) state_nxt = SHIFT;
      end
      SHIFT: begin
        state_nxt = DONE;
      end
      DONE: begin
        ap_done   = 1'b1;
        ap_ready  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register, request capture, per-tap coefficient writes and delay-line shift
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state   <= IDLE;
      tap     <= '0;
      ch_cap  <= '0;
      dlt_cap <= '0;
      for (int c = 0; c < NCH; c++) begin
        for (int i = 0; i < NTAPS; i++) begin
          bli_mem[c][i]  <= '0;
          dlti_mem[c][i] <= '0;
        end
      end
    end else begin
      state <= state_nxt;
      if (state == IDLE && ap_start) begin
        ch_cap  <= ch;
        dlt_cap <= $signed(dlt);
        tap     <= '0;
      end
      if (state == UPD) begin
        tap <= (tap == TAP_LAST) ? '0 : tap + TW'(1);
        if (ch_ok) bli_mem[ch_sel][tap] <= alu_out;
      end
      if (state == SHIFT && ch_ok) begin
        for (int k = NTAPS - 1; k > 0; k--) begin
          dlti_mem[ch_sel][k] <= dlti_mem[ch_sel][k-1];
        end
        dlti_mem[ch_sel][0] <= dlt_cap;
      end
    end
  end

  // Live registered readback; out-of-range addresses read as zero
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      bli_rd  <= '0;
      dlti_rd <= '0;
    end else if (int'(rd_ch) < NCH && int'(rd_idx) < NTAPS) begin
      bli_rd  <= bli_mem[rd_ch][rd_idx];
      dlti_rd <= dlti_mem[rd_ch][rd_idx];
    end else begin
      bli_rd  <= '0;
      dlti_rd <= '0;
    end
  end

endmodule

// File: tb/tb_upzero_mc.sv
// Testbench for upzero_mc (NCH=2, NTAPS=6, defaults otherwise).
// Directed sequences from reset plus randomized updates, checked against a
// behavioural model of the coefficient/delay-line arithmetic. Honors UPZERO_SAT_EN.
module tb_upzero_mc;

  localparam int NCH   = 2;
  localparam int NTAPS = 6;
  localparam int DW    = 32;
  localparam int DLT_W = 17;

  logic             ap_clk = 1'b0;
  logic             ap_rst;
  logic             ap_start;
  logic             ap_done;
  logic             ap_idle;
  logic             ap_ready;
  logic [0:0]       ch;
  logic [DLT_W-1:0] dlt;
  logic [0:0]       rd_ch;
  logic [2:0]       rd_idx;
  logic [DW-1:0]    bli_rd;
  logic [DLT_W-1:0] dlti_rd;

  int vec_cnt = 0;
  int err_cnt = 0;

  longint bli_m  [NCH][NTAPS];
  longint dlti_m [NCH][NTAPS];

  always #5 ap_clk = ~ap_clk;

  upzero_mc #(
    .NCH   (NCH),
    .NTAPS (NTAPS),
    .DW    (DW),
    .DLT_W (DLT_W)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .ap_start (ap_start),
    .ap_done  (ap_done),
    .ap_idle  (ap_idle),
    .ap_ready (ap_ready),
    .ch       (ch),
    .dlt      (dlt),
    .rd_ch    (rd_ch),
    .rd_idx   (rd_idx),
    .bli_rd   (bli_rd),
    .dlti_rd  (dlti_rd)
  );

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Single comparison point: counts every check, reports each mismatch
  task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference coefficient update: floor(b*255/256), then +/-128 by sign of dlt*dlti
  function automatic longint modelTap(longint b, longint d_i, longint d);
    longint x;
    longint q;
    x = b * 255;
    q = x / 256;
    if (x < 0 && (x % 256) != 0) q = q - 1;
    if (d != 0) begin
      if (d * d_i >= 0) q = q + 128;
      else              q = q - 128;
    end
`ifdef UPZERO_SAT_EN
    if (q > 32767)  q = 32767;
    if (q < -32767) q = -32767;
`endif
    return longint'(int'(q));
  endfunction

  task automatic modelUpdate(input int c, input longint d);
    for (int i = 0; i < NTAPS; i++) bli_m[c][i] = modelTap(bli_m[c][i], dlti_m[c][i], d);
    for (int k = NTAPS - 1; k > 0; k--) dlti_m[c][k] = dlti_m[c][k-1];
    dlti_m[c][0] = d;
  endtask

  task automatic modelClear();
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < NTAPS; i++) begin
        bli_m[c][i]  = 0;
        dlti_m[c][i] = 0;
      end
  endtask

  task automatic readBack(input int c, input int i, output longint b, output longint d);
    rd_ch  = 1'(c);
    rd_idx = 3'(i);
    tick();
    b = longint'($signed(bli_rd));
    d = longint'($signed(dlti_rd));
  endtask

  task automatic dumpCheck();
    longint b;
    longint d;
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < NTAPS; i++) begin
        readBack(c, i, b, d);
        checkOutput($sformatf("bli[%0d][%0d]", c, i), b, bli_m[c][i]);
        checkOutput($sformatf("dlti[%0d][%0d]", c, i), d, dlti_m[c][i]);
      end
  endtask

  // Run one update with bounded wait; optionally pulse ap_start while busy
  task automatic applyStimulus(input int c, input longint d, input bit poke_busy);
    int done_at;
    int extra;
    ch       = 1'(c);
    dlt      = 17'(d);
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    done_at  = -1;
    for (int n = 1; n <= 20; n++) begin
      ap_start = poke_busy && (n == 2);
      tick();
      ap_start = 1'b0;
      if (n == 1) checkOutput("busy_idle", ap_idle, 0);
      if (ap_done) begin
        done_at = n;
        break;
      end
    end
    checkOutput("done_lat", done_at, NTAPS + 1);
    checkOutput("ready_pulse", ap_ready, 1);
    modelUpdate(c, d);
    tick();
    checkOutput("idle_back", ap_idle, 1);
    checkOutput("done_drop", ap_done, 0);
    if (poke_busy) begin
      extra = 0;
      repeat (12) begin
        tick();
        if (ap_done) extra++;
      end
      checkOutput("extra_done", extra, 0);
    end
  endtask

  initial begin
    longint b;
    longint d;
    int     extra;
    int     c;
    longint dv;

    ap_rst   = 1'b1;
    ap_start = 1'b0;
    ch       = '0;
    dlt      = '0;
    rd_ch    = '0;
    rd_idx   = '0;
    modelClear();
    repeat (3) tick();
    ap_rst = 1'b0;

    checkOutput("rst_idle", ap_idle, 1);
    checkOutput("rst_done", ap_done, 0);
    checkOutput("rst_ready", ap_ready, 0);
    checkOutput("rst_bli_rd", longint'($signed(bli_rd)), 0);
    checkOutput("rst_dlti_rd", longint'($signed(dlti_rd)), 0);
    dumpCheck();

    applyStimulus(0, 5, 1'b0);
    dumpCheck();
    readBack(0, 0, b, d);
    checkOutput("d1_bli0", b, 128);
    checkOutput("d1_dlti0", d, 5);
    readBack(1, 0, b, d);
    checkOutput("d1_ch1_bli0", b, 0);

    applyStimulus(0, 0, 1'b0);
    dumpCheck();
    readBack(0, 2, b, d);
    checkOutput("d2_bli2", b, 127);
    readBack(0, 1, b, d);
    checkOutput("d2_dlti1", d, 5);

    applyStimulus(0, -3, 1'b0);
    dumpCheck();
    readBack(0, 1, b, d);
    checkOutput("d3_bli1", b, -2);
    readBack(0, 0, b, d);
    checkOutput("d3_bli0", b, 254);
    checkOutput("d3_dlti0", d, -3);

    applyStimulus(0, 0, 1'b1);
    dumpCheck();
    readBack(0, 1, b, d);
    checkOutput("d4_bli1_floor", b, -2);

    applyStimulus(1, 5, 1'b0);
    applyStimulus(1, 5, 1'b0);
    dumpCheck();
    readBack(1, 0, b, d);
    checkOutput("d5_bli0_255", b, 255);

    ch       = 1'b0;
    dlt      = 17'd7;
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    repeat (3) tick();
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    modelClear();
    checkOutput("abort_idle", ap_idle, 1);
    checkOutput("abort_done", ap_done, 0);
    extra = 0;
    repeat (10) begin
      tick();
      if (ap_done) extra++;
    end
    checkOutput("abort_no_done", extra, 0);
    dumpCheck();

    applyStimulus(1, 9, 1'b0);
    dumpCheck();

    for (int r = 0; r < 30; r++) begin
      c = int'($urandom_range(0, NCH - 1));
      if ($urandom_range(0, 3) == 0) dv = 0;
      else dv = longint'($urandom_range(0, 8000)) - 4000;
      applyStimulus(c, dv, 1'b0);
      if (r % 10 == 9) dumpCheck();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
